// File: rtl/rob_commit_unit_if.sv
// Bundles the issue, CDB, operand lookup, retire and status signals of the ROB.
// The slave side is the ROB; the master side is whoever drives issue and the CDB.
interface rob_commit_unit_if #(
  parameter int ROB_Entry_WIDTH = 5
);
  logic                       flush;
  logic                       alloc_valid;
  logic                       alloc_ready;
  logic [4:0]                 alloc_rd;
  logic                       alloc_wen;
  logic [ROB_Entry_WIDTH-1:0] alloc_tag;
  logic                       cdb_valid;
  logic [ROB_Entry_WIDTH-1:0] cdb_tag;
  logic [31:0]                cdb_data;
  logic [ROB_Entry_WIDTH-1:0] lookup_tag1;
  logic [ROB_Entry_WIDTH-1:0] lookup_tag2;
  logic                       lookup_ready1;
  logic                       lookup_ready2;
  logic [31:0]                lookup_data1;
  logic [31:0]                lookup_data2;
  logic                       cmt_valid;
  logic                       cmt_wen;
  logic [ROB_Entry_WIDTH-1:0] cmt_tag;
  logic [4:0]                 cmt_rd;
  logic [31:0]                cmt_data;
  logic [ROB_Entry_WIDTH-1:0] count;
  logic                       empty;
  logic                       full;

  modport slave (
    input  flush, alloc_valid, alloc_rd, alloc_wen,
    input  cdb_valid, cdb_tag, cdb_data,
    input  lookup_tag1, lookup_tag2,
    output alloc_ready, alloc_tag,
    output lookup_ready1, lookup_ready2, lookup_data1, lookup_data2,
    output cmt_valid, cmt_wen, cmt_tag, cmt_rd, cmt_data,
    output count, empty, full
  );

  modport master (
    output flush, alloc_valid, alloc_rd, alloc_wen,
    output cdb_valid, cdb_tag, cdb_data,
    output lookup_tag1, lookup_tag2,
    input  alloc_ready, alloc_tag,
    input  lookup_ready1, lookup_ready2, lookup_data1, lookup_data2,
    input  cmt_valid, cmt_wen, cmt_tag, cmt_rd, cmt_data,
    input  count, empty, full
  );
endinterface

// File: rtl/rob_commit_unit.sv
// In-order reorder buffer: allocates tags at issue, captures CDB results,
// retires the head entry into the register file write port. Tag 0 means
// "no producer", so entry 0 is never allocated and pointers wrap MAX -> 1.
module rob_commit_unit #(
  parameter int ROB_Entry_WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  rob_commit_unit_if.slave bus
);
  localparam int W   = ROB_Entry_WIDTH;
  localparam int MAX = (1 << W) - 1;

  // Control state needs reset; payload does not (it is only read when busy/ready).
  logic [MAX:0]  busy;
  logic [MAX:0]  ready;
  logic          wen  [0:MAX];
  logic [4:0]    rd   [0:MAX];
  logic [31:0]   data [0:MAX];

  logic [W-1:0]  head;
  logic [W-1:0]  tail;
  logic [W-1:0]  count;
  logic          cmt_valid;
  logic          cmt_wen;
  logic [W-1:0]  cmt_tag;
  logic [4:0]    cmt_rd;
  logic [31:0]   cmt_data;

  logic          is_full;
  logic          do_alloc;
  logic          do_commit;
  logic          cdb_hit;

  function automatic logic [W-1:0] next_ptr(input logic [W-1:0] p);
    return (p == W'(MAX)) ? W'(1) : p + W'(1);
  endfunction

  assign is_full   = (count == W'(MAX));
  // Refusal looks only at the current count, so a same-cycle commit does not free a slot.
  assign do_alloc  = bus.alloc_valid && !is_full;
  // Commit uses the pre-edge ready bit, so a CDB write to the head retires one cycle later.
  assign do_commit = busy[head] && ready[head];
  assign cdb_hit   = bus.cdb_valid && (bus.cdb_tag != '0) && busy[bus.cdb_tag];

  // Pointers, occupancy, entry flags and the registered retire port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= W'(1);
      tail      <= W'(1);
      count     <= '0;
      busy      <= '0;
      ready     <= '0;
      cmt_valid <= 1'b0;
      cmt_wen   <= 1'b0;
      cmt_tag   <= '0;
      cmt_rd    <= '0;
      cmt_data  <= '0;
    end else if (bus.flush) begin
      head      <= W'(1);
      tail      <= W'(1);
      count     <= '0;
      busy      <= '0;
      ready     <= '0;
      cmt_valid <= 1'b0;
      cmt_wen   <= 1'b0;
      cmt_tag   <= '0;
      cmt_rd    <= '0;
      cmt_data  <= '0;
    end else begin
      cmt_valid <= do_commit;
      cmt_wen   <= do_commit && wen[head] && (rd[head] != 5'd0);
      if (do_commit) begin
        cmt_tag  <= head;
        cmt_rd   <= rd[head];
        cmt_data <= data[head];
      end
      // Order matters: the commit clear must win over a duplicate CDB write to the head.
      if (cdb_hit) begin
        ready[bus.cdb_tag] <= 1'b1;
      end
      if (do_commit) begin
        busy[head]  <= 1'b0;
        ready[head] <= 1'b0;
        head        <= next_ptr(head);
      end
      if (do_alloc) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= 1'b0;
        tail        <= next_ptr(tail);
      end
      case ({do_alloc, do_commit})
        2'b10:   count <= count + W'(1);
        2'b01:   count <= count - W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload: destination info at allocation, result value from the CDB.
  always_ff @(posedge clk) begin
    if (do_alloc && !bus.flush) begin
      wen[tail] <= bus.alloc_wen;
      rd[tail]  <= bus.alloc_rd;
    end
    if (cdb_hit && !bus.flush) begin
      data[bus.cdb_tag] <= bus.cdb_data;
    end
  end

  // Operand lookup: CDB bypass first, then a completed entry, else not available.
  always_comb begin
    bus.lookup_ready1 = 1'b0;
    bus.lookup_data1  = '0;
    bus.lookup_ready2 = 1'b0;
    bus.lookup_data2  = '0;
    if (bus.cdb_valid && (bus.cdb_tag == bus.lookup_tag1) && (bus.lookup_tag1 != '0)) begin
      bus.lookup_ready1 = 1'b1;
      bus.lookup_data1  = bus.cdb_data;
    end else if (busy[bus.lookup_tag1] && ready[bus.lookup_tag1]) begin
      bus.lookup_ready1 = 1'b1;
      bus.lookup_data1  = data[bus.lookup_tag1];
    end
    if (bus.cdb_valid && (bus.cdb_tag == bus.lookup_tag2) && (bus.lookup_tag2 != '0)) begin
      bus.lookup_ready2 = 1'b1;
      bus.lookup_data2  = bus.cdb_data;
    end else if (busy[bus.lookup_tag2] && ready[bus.lookup_tag2]) begin
      bus.lookup_ready2 = 1'b1;
      bus.lookup_data2  = data[bus.lookup_tag2];
    end
  end

  assign bus.alloc_ready = !is_full;
  assign bus.alloc_tag   = tail;
  assign bus.count       = count;
  assign bus.empty       = (count == '0);
  assign bus.full        = is_full;
  assign bus.cmt_valid   = cmt_valid;
  assign bus.cmt_wen     = cmt_wen;
  assign bus.cmt_tag     = cmt_tag;
  assign bus.cmt_rd      = cmt_rd;
  assign bus.cmt_data    = cmt_data;
endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- In-order reorder buffer for the SSOOO core. Allocates ROB tags at issue, captures results from the common data bus (CDB), and retires the head entry.
- The retire outputs drive the register file write port: cmt_wen, cmt_tag, cmt_rd and cmt_data feed the regfile WP1_Wen, WP1_ROBEN, WP1_DRindex and WP1_Data inputs.
- Tag 0 is reserved to mean "no producer". Valid tags run from 1 to 2^ROB_Entry_WIDTH-1.

Parameters:
- ROB_Entry_WIDTH, 5, tag width. Capacity is 2^ROB_Entry_WIDTH-1 entries.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous squash of all entries
- alloc_valid  in  1  issue requests an entry
- alloc_ready  out  1  entry available (not full)
- alloc_rd  in  5  destination register index
- alloc_wen  in  1  instruction writes a register
- alloc_tag  out  ROB_Entry_WIDTH  tag assigned on an accepted alloc (current tail)
- cdb_valid  in  1  result broadcast
- cdb_tag  in  ROB_Entry_WIDTH  producer tag
- cdb_data  in  32  result value
- lookup_tag1, lookup_tag2  in  ROB_Entry_WIDTH  operand tags to query
- lookup_ready1, lookup_ready2  out  1  value available for the queried tag
- lookup_data1, lookup_data2  out  32  value for the queried tag
- cmt_valid  out  1  one-cycle retire pulse
- cmt_wen  out  1  retire writes the register file
- cmt_tag  out  ROB_Entry_WIDTH  retired tag
- cmt_rd  out  5  retired destination register
- cmt_data  out  32  retired value
- count  out  ROB_Entry_WIDTH  occupied entries
- empty  out  1  count==0
- full  out  1  count==2^ROB_Entry_WIDTH-1

Behaviour:
- Entry state: busy, ready, wen, rd[4:0], data[31:0]. Head pointer and tail pointer range 1..MAX, where MAX=2^ROB_Entry_WIDTH-1. Both wrap from MAX to 1, never to 0.
- Reset (async): all entries have busy=0 and ready=0. head=tail=1, count=0. All cmt_* outputs are 0, so alloc_tag=1, empty=1, full=0.
- alloc_ready = !full, evaluated on the current count. When full, an alloc is refused even if a commit happens in the same cycle.
- Accepted alloc (alloc_valid && alloc_ready) at the edge: entry[tail] is written with busy=1, ready=0, wen=alloc_wen, rd=alloc_rd. Then tail advances.
- CDB write at the edge: if cdb_valid, cdb_tag!=0 and entry[cdb_tag] is busy, then data=cdb_data and ready=1.
  - Any other CDB write (tag 0, or a non-busy entry) is ignored.
  - A duplicate CDB write to a ready entry overwrites its data.
- Commit (max 1 per cycle): at the edge, if entry[head] is busy and ready, as registered before the edge:
  - cmt_valid=1
  - cmt_tag=head
  - cmt_rd=rd
  - cmt_data=data
  - cmt_wen = wen && rd!=0
  - The entry is cleared and head advances.
  - Otherwise cmt_valid=0 and cmt_wen=0; cmt_tag, cmt_rd and cmt_data hold their values.
- A CDB write to the head entry in the same cycle does not commit that cycle. It commits at the next edge.
- Minimum latency: alloc at edge N, CDB at edge N+1, cmt_valid high after edge N+2.
- count: +1 on alloc, -1 on commit, unchanged when both occur.
- Lookup (combinational):
  - If cdb_valid && cdb_tag==lookup_tag && tag!=0: ready=1, data=cdb_data (bypass).
  - Else if entry[tag] is busy and ready: ready=1, data=entry.data.
  - Else: ready=0, data=0.
  - Tag 0 always returns ready=0.
- flush (synchronous) has priority over alloc, CDB and commit in the same cycle. State returns to the reset state, including the cmt_* outputs.
- Asynchronous rst mid-operation discards all entries immediately.
- The regfile latches tags on negedge and data on posedge. cmt_* are registered on posedge, so they are stable across the regfile's posedge sample one cycle later.

Test Plan:
- ROB_Entry_WIDTH=3: reset, then 3 allocs (rd=1,2,3, wen=1) -> alloc_tag sequence 1,2,3; count=3; empty=0.
- CDB tag2=0xAA, then tag1=0x55 -> tag1 commits (cmt_rd=1, data 0x55), then tag2 the next cycle (0xAA). tag3 does not commit.
- Fill 7 entries -> full=1, alloc_ready=0. Commit one while alloc_valid=1 -> alloc refused that cycle. Next alloc gets tag 1 (wrap, skips 0).
- lookup_tag1=3 with cdb_valid, cdb_tag=3, cdb_data=0x1234 in the same cycle -> lookup_ready1=1, lookup_data1=0x1234. Query tag 0 -> ready=0.
- Alloc with rd=0, wen=1, then CDB -> cmt_valid=1, cmt_wen=0. CDB to a non-busy tag 5 -> no state change.
- flush asserted together with alloc and CDB -> count=0, alloc_tag=1, cmt_valid=0. Async rst mid-fill -> empty=1 immediately.
